// File: rtl/lower_tri_matvec_q.sv
// y = Linv * x for an in-place unit-lower-triangular inverse, signed Q-format.
// Streams y in row order over a valid/ready port; one term is accumulated at a time.
module lower_tri_matvec_q #(
  parameter int unsigned N        = 4,
  parameter int unsigned Q        = 24,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   mat_rd_en,
  output logic [$clog2(N*N)-1:0] mat_rd_addr,
  input  logic [WIDTH-1:0]       mat_rd_data,
  output logic                   vec_rd_en,
  output logic [$clog2(N)-1:0]   vec_rd_addr,
  input  logic [WIDTH-1:0]       vec_rd_data,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [WIDTH-1:0]       y_data,
  output logic [$clog2(N)-1:0]   y_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ADDR_W = $clog2(N*N);
  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned PROD_W = 2*WIDTH;
  localparam int unsigned ACC_W  = 2*WIDTH + $clog2(N);
  localparam int unsigned CNT_W  = $clog2(MULT_LAT+2);

  typedef enum logic [3:0] {
    S_IDLE, S_ROW_INIT, S_WAIT_X, S_LOAD_X, S_ISSUE, S_WAIT, S_ACC, S_OUT, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           i_q, i_d, k_q, k_d;
  logic [CNT_W-1:0]           wcnt_q, wcnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0]    x_q, x_d;
  logic signed [WIDTH-1:0]    op_a_q, op_b_q;
  logic signed [PROD_W-1:0]   prod_q [MULT_LAT];
  logic                       mat_rd_en_q, mat_rd_en_d, vec_rd_en_q, vec_rd_en_d;
  logic [ADDR_W-1:0]          mat_rd_addr_q, mat_rd_addr_d;
  logic [IDX_W-1:0]           vec_rd_addr_q, vec_rd_addr_d;
  logic                       y_valid_q, y_valid_d;
  logic [WIDTH-1:0]           y_data_q, y_data_d;
  logic [IDX_W-1:0]           y_idx_q, y_idx_d;
  logic                       busy_q, busy_d, done_q, done_d;

  // Next-state and next-output logic; outputs are registered from state_d.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    k_d           = k_q;
    wcnt_d        = wcnt_q;
    acc_d         = acc_q;
    x_d           = x_q;
    mat_rd_en_d   = 1'b0;
    vec_rd_en_d   = 1'b0;
    mat_rd_addr_d = mat_rd_addr_q;
    vec_rd_addr_d = vec_rd_addr_q;
    y_data_d      = y_data_q;
    y_idx_d       = y_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROW_INIT;
          i_d     = '0;
        end
      end
      S_ROW_INIT: state_d = S_WAIT_X;
      S_WAIT_X: begin
        x_d     = vec_rd_data;
        state_d = S_LOAD_X;
      end
      S_LOAD_X: begin
        acc_d   = ACC_W'(x_q) <<< Q;
        k_d     = '0;
        state_d = (i_q == '0) ? S_OUT : S_ISSUE;
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      // One cycle for RAM data, then MULT_LAT multiplier stages.
      S_WAIT: begin
        if (wcnt_q == CNT_W'(MULT_LAT)) state_d = S_ACC;
        else                            wcnt_d  = wcnt_q + CNT_W'(1);
      end
      S_ACC: begin
        acc_d = acc_q + ACC_W'(prod_q[MULT_LAT-1]);
        if (k_q + IDX_W'(1) < i_q) begin
          k_d     = k_q + IDX_W'(1);
          state_d = S_ISSUE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (y_ready) begin
          if (i_q == IDX_W'(N-1)) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + IDX_W'(1);
            state_d = S_ROW_INIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ROW_INIT) begin
      vec_rd_en_d   = 1'b1;
      vec_rd_addr_d = i_d;
    end
    if (state_d == S_ISSUE) begin
      mat_rd_en_d   = 1'b1;
      vec_rd_en_d   = 1'b1;
      mat_rd_addr_d = ADDR_W'(32'(i_q) * N + 32'(k_d));
      vec_rd_addr_d = k_d;
    end
    // Result is latched once on OUT entry and held through backpressure.
    if (state_d == S_OUT && state_q != S_OUT) begin
      y_data_d = WIDTH'(acc_d >>> Q);
      y_idx_d  = i_q;
    end
    y_valid_d = (state_d == S_OUT);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      k_q           <= '0;
      wcnt_q        <= '0;
      acc_q         <= '0;
      x_q           <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      for (int j = 0; j < MULT_LAT; j++) prod_q[j] <= '0;
      mat_rd_en_q   <= 1'b0;
      vec_rd_en_q   <= 1'b0;
      mat_rd_addr_q <= '0;
      vec_rd_addr_q <= '0;
      y_valid_q     <= 1'b0;
      y_data_q      <= '0;
      y_idx_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      k_q           <= k_d;
      wcnt_q        <= wcnt_d;
      acc_q         <= acc_d;
      x_q           <= x_d;
      op_a_q        <= mat_rd_data;
      op_b_q        <= vec_rd_data;
      prod_q[0]     <= PROD_W'(op_a_q) * PROD_W'(op_b_q);
      for (int j = 1; j < MULT_LAT; j++) prod_q[j] <= prod_q[j-1];
      mat_rd_en_q   <= mat_rd_en_d;
      vec_rd_en_q   <= vec_rd_en_d;
      mat_rd_addr_q <= mat_rd_addr_d;
      vec_rd_addr_q <= vec_rd_addr_d;
      y_valid_q     <= y_valid_d;
      y_data_q      <= y_data_d;
      y_idx_q       <= y_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mat_rd_en   = mat_rd_en_q;
  assign mat_rd_addr = mat_rd_addr_q;
  assign vec_rd_en   = vec_rd_en_q;
  assign vec_rd_addr = vec_rd_addr_q;
  assign y_valid     = y_valid_q;
  assign y_data      = y_data_q;
  assign y_idx       = y_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_lower_tri_matvec_q.sv
// Bench for lower_tri_matvec_q: directed table of matrix/vector cases with
// hand-computed results, backpressure, stray starts, mid-run reset, random runs.
module tb_lower_tri_matvec_q;

  localparam int N  = 4;
  localparam int ML = 1;
  localparam int T0 = 4*N + (N*(N-1)/2)*(3+ML);

  typedef struct packed {
    logic [N*N-1:0][31:0] mat;
    logic [N-1:0][31:0]   x;
    logic [N-1:0][31:0]   y;
    int                   stall_row;
    bit                   start_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, y_ready;
  logic        mat_rd_en, vec_rd_en, y_valid, busy, done;
  logic [3:0]  mat_rd_addr;
  logic [1:0]  vec_rd_addr, y_idx;
  logic [31:0] mat_rd_data, vec_rd_data, y_data;

  logic [31:0] mat_mem [N*N];
  logic [31:0] vec_mem [N];
  int          rd_err = 0;
  int          n_vec = 0, n_err = 0;
  vec_t        tbl [6];

  always #5 clk = ~clk;

  lower_tri_matvec_q #(.N(N), .Q(24), .WIDTH(32), .MULT_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mat_rd_en(mat_rd_en), .mat_rd_addr(mat_rd_addr), .mat_rd_data(mat_rd_data),
    .vec_rd_en(vec_rd_en), .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx),
    .busy(busy), .done(done)
  );

  // Synchronous-read RAMs; also flags any read of the diagonal or upper triangle.
  always @(posedge clk) begin
    if (mat_rd_en) mat_rd_data <= mat_mem[mat_rd_addr];
    if (vec_rd_en) vec_rd_data <= vec_mem[vec_rd_addr];
    if (mat_rd_en && (int'(mat_rd_addr) % N >= int'(mat_rd_addr) / N)) rd_err <= rd_err + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_strobes"}, 32'({mat_rd_en, vec_rd_en, y_valid, busy, done}), 32'h0);
    chk({tag, "_mat_addr"}, 32'(mat_rd_addr), 32'h0);
    chk({tag, "_vec_addr"}, 32'(vec_rd_addr), 32'h0);
    chk({tag, "_y_data"}, y_data, 32'h0);
    chk({tag, "_y_idx"}, 32'(y_idx), 32'h0);
  endtask

  function automatic logic [31:0] model_y(input vec_t v, input int i);
    longint s;
    s = longint'($signed(v.x[i])) <<< 24;
    for (int k = 0; k < i; k++) s += longint'($signed(v.mat[i*N+k])) * longint'($signed(v.x[k]));
    return 32'(s >>> 24);
  endfunction

  function automatic logic [31:0] rnd2();
    logic [31:0] r;
    r = $urandom_range(0, 32'h0400_0000);
    return r - 32'h0200_0000;
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    int t, got, last_hs, done_t, dones, stall_left, stall_err, rd_base, exp_hs;
    logic prev_stalled;
    logic [31:0] pd;
    logic [1:0]  pi;
    for (int a = 0; a < N*N; a++) mat_mem[a] = v.mat[a];
    for (int a = 0; a < N; a++) vec_mem[a] = v.x[a];
    got = 0; last_hs = -1; done_t = -1; dones = 0; stall_err = 0;
    stall_left = (v.stall_row >= 0) ? 5 : 0;
    exp_hs = T0 + ((v.stall_row >= 0) ? 5 : 0);
    prev_stalled = 1'b0; pd = '0; pi = '0;
    rd_base = rd_err;
    y_ready = 1'b1;
    @(negedge clk); start = 1'b1; t = 0;
    @(negedge clk); start = 1'b0; t = 1;
    chk({tag, "_busy_on"}, 32'(busy), 32'h1);
    while (t < 400 && (done_t < 0 || t < done_t + 4)) begin
      @(negedge clk); t++;
      start = 1'b0;
      if (prev_stalled && (!y_valid || y_data !== pd || y_idx !== pi)) stall_err++;
      if (y_valid && int'(y_idx) == v.stall_row && stall_left > 0) begin
        y_ready = 1'b0;
        stall_left--;
      end else begin
        y_ready = 1'b1;
      end
      prev_stalled = y_valid && !y_ready;
      pd = y_data; pi = y_idx;
      if (prev_stalled && (mat_rd_en || vec_rd_en)) stall_err++;
      if (y_valid && y_ready) begin
        if (got < N) begin
          chk($sformatf("%s_y%0d", tag, got), y_data, v.y[got]);
          chk($sformatf("%s_idx%0d", tag, got), 32'(y_idx), 32'(got));
        end
        got++;
        last_hs = t;
      end
      if (done) begin
        dones++;
        if (done_t < 0) done_t = t;
        if (v.start_busy) start = 1'b1;
      end
      if (v.start_busy && t == 12) start = 1'b1;
    end
    start = 1'b0;
    y_ready = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(N));
    chk({tag, "_last_hs"}, 32'(last_hs), 32'(exp_hs));
    chk({tag, "_done_t"}, 32'(done_t), 32'(exp_hs + 1));
    chk({tag, "_dones"}, 32'(dones), 32'h1);
    chk({tag, "_idle_after"}, 32'({busy, y_valid, done}), 32'h0);
    chk({tag, "_upper_rd"}, 32'(rd_err - rd_base), 32'h0);
    chk({tag, "_stall"}, 32'(stall_err), 32'h0);
  endtask

  initial begin
    vec_t v;
    bit   found;
    rst_n = 1'b0; start = 1'b0; y_ready = 1'b1;
    mat_rd_data = '0; vec_rd_data = '0;

    for (int c = 0; c < 6; c++) begin
      tbl[c] = '0;
      tbl[c].stall_row = -1;
    end
    // Identity: y = x
    tbl[0].x[0] = 32'h0100_0000; tbl[0].x[1] = 32'h0200_0000;
    tbl[0].x[2] = 32'hFD00_0000; tbl[0].x[3] = 32'h0080_0000;
    tbl[0].y = tbl[0].x;
    // 0.5 * 1.0 into row 1
    tbl[1].mat[4] = 32'h0080_0000; tbl[1].x[0] = 32'h0100_0000;
    tbl[1].y[0] = 32'h0100_0000; tbl[1].y[1] = 32'h0080_0000;
    // 0.5 + (-1.0)(2.0) = -1.5 in row 3
    tbl[2].mat[12] = 32'hFF00_0000; tbl[2].x[0] = 32'h0200_0000; tbl[2].x[3] = 32'h0080_0000;
    tbl[2].y[0] = 32'h0200_0000; tbl[2].y[3] = 32'hFE80_0000;
    // Diagonal/upper full of 0x7FFFFFFF must be ignored; stray starts too
    tbl[3] = tbl[0];
    for (int r = 0; r < N; r++)
      for (int c = r; c < N; c++) tbl[3].mat[r*N+c] = 32'h7FFF_FFFF;
    tbl[3].start_busy = 1'b1;
    // Full lower triangle with 5 cycles of backpressure on row 2
    tbl[4].mat[4]  = 32'h0100_0000; tbl[4].mat[8]  = 32'h0040_0000; tbl[4].mat[9]  = 32'hFF80_0000;
    tbl[4].mat[13] = 32'h0200_0000; tbl[4].mat[14] = 32'h00C0_0000;
    tbl[4].x[0] = 32'h0100_0000; tbl[4].x[1] = 32'h0200_0000;
    tbl[4].x[2] = 32'hFF00_0000; tbl[4].x[3] = 32'h0080_0000;
    tbl[4].y[0] = 32'h0100_0000; tbl[4].y[1] = 32'h0300_0000;
    tbl[4].y[2] = 32'hFE40_0000; tbl[4].y[3] = 32'h03C0_0000;
    tbl[4].stall_row = 2;
    // Wrap on overflow and floor on negative truncation
    tbl[5].mat[4] = 32'h7FFF_FFFF; tbl[5].mat[8] = 32'hFFFF_FFFF; tbl[5].x[0] = 32'h7FFF_FFFF;
    tbl[5].y[0] = 32'h7FFF_FFFF; tbl[5].y[1] = 32'hFFFF_FF00; tbl[5].y[2] = 32'hFFFF_FF80;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int c = 0; c < 6; c++) run_case(tbl[c], $sformatf("vec%0d", c));

    // Reset while row 2 waits on its first product, then a clean rerun
    for (int a = 0; a < N*N; a++) mat_mem[a] = tbl[4].mat[a];
    for (int a = 0; a < N; a++) vec_mem[a] = tbl[4].x[a];
    y_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      @(negedge clk);
      if (mat_rd_en && mat_rd_addr == 4'd8) found = 1'b1;
    end
    chk("midrst_found_row2", 32'(found), 32'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_quiet", 32'({busy, y_valid, done}), 32'h0);
    v = tbl[4];
    v.stall_row = -1;
    run_case(v, "after_rst");

    for (int r = 0; r < 50; r++) begin
      v = '0;
      v.stall_row = -1;
      for (int a = 0; a < N*N; a++) v.mat[a] = (a % N < a / N) ? rnd2() : 32'($urandom);
      for (int a = 0; a < N; a++) v.x[a] = rnd2();
      for (int a = 0; a < N; a++) v.y[a] = model_y(v, a);
      run_case(v, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
